// File: rtl/mips_pkg.sv
// mips_pkg: shared word width, NOP encoding and instruction-memory FSM states.
package mips_pkg;
  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] NOP_INSTR = 32'h0000_0000;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} imem_state_t;
endpackage

// File: rtl/imem_responder_if.sv
// imem_responder_if: fetch request/response handshake plus program-loader port.
interface imem_responder_if #(parameter int IDX_W = 12);
  logic             req_valid;
  logic             req_ready;
  logic [31:0]      req_pc;
  logic             flush;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_instr;
  logic [31:0]      rsp_pc_plus_four;
  logic             rsp_fault;
  logic             load_en;
  logic [IDX_W-1:0] load_addr;
  logic [31:0]      load_data;
  modport master (
    output req_valid, req_pc, flush, rsp_ready, load_en, load_addr, load_data,
    input  req_ready, rsp_valid, rsp_instr, rsp_pc_plus_four, rsp_fault
  );
  modport slave (
    input  req_valid, req_pc, flush, rsp_ready, load_en, load_addr, load_data,
    output req_ready, rsp_valid, rsp_instr, rsp_pc_plus_four, rsp_fault
  );
endinterface

// File: rtl/imem_array.sv
// imem_array: DEPTH x 32 instruction store, one load write port, one registered
// read port that returns same-edge write data (write-first).
module imem_array
  import mips_pkg::*;
#(
  parameter int DEPTH = 4096,
  parameter int IDX_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic              re,
  input  logic              clr,
  input  logic [IDX_W-1:0]  raddr,
  output logic [WORD_W-1:0] rdata
);
  localparam logic [IDX_W:0] LIMIT = (IDX_W+1)'(DEPTH);
  logic [WORD_W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we && {1'b0, waddr} < LIMIT) mem[waddr] <= wdata;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rdata <= NOP_INSTR;
    else if (clr) rdata <= NOP_INSTR;
    else if (re) rdata <= (we && waddr == raddr) ? wdata : mem[raddr];
endmodule

// File: rtl/imem_responder.sv
// imem_responder: memory side of the fetch interface; fixed-latency instruction
// responses with backpressure, flush and fault reporting.
module imem_responder
  import mips_pkg::*;
#(
  parameter int DEPTH   = 4096,
  parameter int LATENCY = 2,
  parameter int IDX_W   = 12
) (
  input logic             clk,
  input logic             rst_n,
  imem_responder_if.slave bus
);
  localparam logic [3:0]  CNT_INIT = LATENCY > 1 ? 4'(LATENCY - 2) : 4'd0;
  localparam logic [29:0] WORDS    = 30'(DEPTH);
  imem_state_t state, nxt;
  logic [3:0]  cnt, cnt_d;
  logic [31:0] pc_q, rd_pc;
  logic        accept, enter, fault;
  assign bus.req_ready = rst_n && !bus.flush && (state == IDLE || (state == RESP && bus.rsp_ready));
  assign accept        = bus.req_valid && bus.req_ready;
  assign bus.rsp_valid = state == RESP;
  // With LATENCY==1 the read happens on the accept edge, before pc_q is loaded.
  assign rd_pc = state == WAIT ? pc_q : bus.req_pc;
  assign fault = rd_pc[1:0] != 2'b00 || rd_pc[31:2] >= WORDS;
  always_comb begin
    nxt   = state;
    cnt_d = cnt;
    enter = 1'b0;
    if (bus.flush) nxt = IDLE;
    else if (state == WAIT) begin
      cnt_d = cnt == 4'd0 ? cnt : cnt - 4'd1;
      nxt   = cnt == 4'd0 ? RESP : WAIT;
      enter = cnt == 4'd0;
    end else if (accept) begin
      nxt   = LATENCY == 1 ? RESP : WAIT;
      cnt_d = CNT_INIT;
      enter = LATENCY == 1;
    end else if (state == RESP && bus.rsp_ready) nxt = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state                <= IDLE;
      cnt                  <= 4'd0;
      pc_q                 <= 32'd0;
      bus.rsp_pc_plus_four <= 32'd0;
      bus.rsp_fault        <= 1'b0;
    end else begin
      state <= nxt;
      cnt   <= cnt_d;
      if (accept) pc_q <= bus.req_pc;
      if (enter) begin
        bus.rsp_pc_plus_four <= rd_pc + 32'd4;
        bus.rsp_fault        <= fault;
      end
    end
  imem_array #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_array (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (bus.load_en),
    .waddr(bus.load_addr),
    .wdata(bus.load_data),
    .re   (enter && !fault),
    .clr  (enter && fault),
    .raddr(rd_pc[IDX_W+1:2]),
    .rdata(bus.rsp_instr)
  );
endmodule
